// File: rtl/stage4_mem_pkg.sv
// Shared types and constants for the memory-access stage.
package fullsend_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned EXM_N = 4;
  localparam int unsigned MWB_N = 3;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned EXM_IR   = 0;
  localparam int unsigned EXM_COND = 1;
  localparam int unsigned EXM_ALU  = 2;
  localparam int unsigned EXM_B    = 3;

  localparam int unsigned MWB_IR  = 0;
  localparam int unsigned MWB_LMD = 1;
  localparam int unsigned MWB_ALU = 2;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} mem_state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} acc_size_t;

  // Access width of a memop; unlisted funct3 codes fall back to a word.
  function automatic acc_size_t acc_size(input logic is_load, input logic [2:0] f3);
    acc_size_t sz;
    sz = SZ_W;
    case (f3)
      F3_B:  sz = SZ_B;
      F3_H:  sz = SZ_H;
      F3_W:  sz = SZ_W;
      F3_BU: sz = is_load ? SZ_B : SZ_W;
      F3_HU: sz = is_load ? SZ_H : SZ_W;
      default: sz = SZ_W;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/stage4_mem_if.sv
// Request/grant/rvalid data-memory port.
interface stage4_mem_if import fullsend_pkg::*; ();
  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic [3:0]      dmem_be;
  logic            dmem_gnt;
  logic            dmem_rvalid;
  logic [XLEN-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/stage4_mem_load_align.sv
// Load data lane extraction and sign/zero extension.
module load_align import fullsend_pkg::*; (
  input  logic [XLEN-1:0] rdata_i,
  input  logic [1:0]      addr_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] lmd_c_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Pick the addressed byte/halfword and extend per funct3.
  always_comb begin
    byte_v  = rdata_i[{addr_i, 3'b000} +: 8];
    half_v  = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    lmd_c_o = rdata_i;
    case (funct3_i)
      F3_B:  lmd_c_o = {{24{byte_v[7]}}, byte_v};
      F3_BU: lmd_c_o = {24'h0, byte_v};
      F3_H:  lmd_c_o = {{16{half_v[15]}}, half_v};
      F3_HU: lmd_c_o = {16'h0, half_v};
      default: lmd_c_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/stage4_mem.sv
// Memory-access stage: issues loads/stores on the dmem port, stalls
// upstream while an access is outstanding, and writes MEM/WB.
// Build option: MISALIGN_TRAP_EN traps misaligned memops instead of issuing.
module stage4_mem import fullsend_pkg::*; #(
  parameter int unsigned RESP_TIMEOUT = 256
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [EXM_N-1:0][XLEN-1:0] ex_mem,
  input  logic                       ex_valid,
  output logic                       mem_stall,
  stage4_mem_if.master               dmem,
  output logic [MWB_N-1:0][XLEN-1:0] mem_wb,
  output logic                       wb_valid,
  output logic                       mem_err
);

  localparam int unsigned CNT_W = $clog2(RESP_TIMEOUT + 1);

  mem_state_t                 state_q, state_d;
  logic [MWB_N-1:0][XLEN-1:0] mem_wb_q, mem_wb_d;
  logic                       wb_valid_q, wb_valid_d;
  logic                       mem_err_q, mem_err_d;
  logic                       req_q, req_d;
  logic                       we_q, we_d;
  logic [XLEN-1:0]            addr_q, addr_d;
  logic [XLEN-1:0]            wdata_q, wdata_d;
  logic [3:0]                 be_q, be_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;

  logic [XLEN-1:0] ir, ea, sdata, lmd, st_wdata;
  logic [3:0]      st_be;
  logic            is_load, is_store, memop, trap_c, timeout_c;
  acc_size_t       size;
  logic            unused_ok;

  assign ir       = ex_mem[EXM_IR];
  assign ea       = ex_mem[EXM_ALU];
  assign sdata    = ex_mem[EXM_B];
  assign is_load  = (ir[6:0] == OP_LOAD);
  assign is_store = (ir[6:0] == OP_STORE);
  assign memop    = is_load | is_store;
  assign size     = acc_size(is_load, ir[14:12]);
  assign unused_ok = ^{ex_mem[EXM_COND], ir[31:15], ir[11:7]};

`ifdef MISALIGN_TRAP_EN
  assign trap_c = memop & (((size == SZ_H) & ea[0]) | ((size == SZ_W) & (ea[1:0] != 2'b00)));
`else
  assign trap_c = 1'b0;
`endif

  // The Nth WAIT cycle without rvalid is the last one allowed.
  assign timeout_c = (cnt_q == CNT_W'(RESP_TIMEOUT - 1));

  load_align u_load_align (
    .rdata_i  (dmem.dmem_rdata),
    .addr_i   (ea[1:0]),
    .funct3_i (ir[14:12]),
    .lmd_c_o  (lmd)
  );

  // Store byte enables and lane-replicated write data.
  always_comb begin
    st_be    = 4'hF;
    st_wdata = sdata;
    case (size)
      SZ_B: begin
        st_be    = 4'b0001 << ea[1:0];
        st_wdata = {4{sdata[7:0]}};
      end
      SZ_H: begin
        st_be    = ea[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{sdata[15:0]}};
      end
      default: begin
        st_be    = 4'hF;
        st_wdata = sdata;
      end
    endcase
  end

  // Next-state, stall and MEM/WB update logic.
  always_comb begin
    state_d    = state_q;
    mem_wb_d   = mem_wb_q;
    wb_valid_d = 1'b0;
    mem_err_d  = 1'b0;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    cnt_d      = cnt_q;
    mem_stall  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ex_valid) begin
          // Non-memops and trapped memops retire in one cycle without stalling.
          if (!memop || trap_c) begin
            mem_wb_d[MWB_IR]  = ir;
            mem_wb_d[MWB_LMD] = '0;
            mem_wb_d[MWB_ALU] = ea;
            wb_valid_d        = 1'b1;
            mem_err_d         = trap_c;
          end else begin
            mem_stall = 1'b1;
            req_d     = 1'b1;
            we_d      = is_store;
            addr_d    = {ea[XLEN-1:2], 2'b00};
            wdata_d   = st_wdata;
            be_d      = st_be;
            state_d   = REQ;
          end
        end
      end
      REQ: begin
        mem_stall = !(dmem.dmem_gnt && we_q);
        if (dmem.dmem_gnt) begin
          req_d = 1'b0;
          if (we_q) begin
            mem_wb_d[MWB_IR]  = ir;
            mem_wb_d[MWB_LMD] = '0;
            mem_wb_d[MWB_ALU] = ea;
            wb_valid_d        = 1'b1;
            state_d           = IDLE;
          end else begin
            cnt_d   = '0;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (dmem.dmem_rvalid) begin
          mem_wb_d[MWB_IR]  = ir;
          mem_wb_d[MWB_LMD] = lmd;
          mem_wb_d[MWB_ALU] = ea;
          wb_valid_d        = 1'b1;
          state_d           = IDLE;
        end else if (timeout_c) begin
          mem_wb_d[MWB_IR]  = ir;
          mem_wb_d[MWB_LMD] = '0;
          mem_wb_d[MWB_ALU] = ea;
          wb_valid_d        = 1'b1;
          mem_err_d         = 1'b1;
          state_d           = IDLE;
        end else begin
          cnt_d     = cnt_q + CNT_W'(1);
          mem_stall = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      mem_wb_q   <= '0;
      wb_valid_q <= 1'b0;
      mem_err_q  <= 1'b0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      mem_wb_q   <= mem_wb_d;
      wb_valid_q <= wb_valid_d;
      mem_err_q  <= mem_err_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      cnt_q      <= cnt_d;
    end
  end

  assign mem_wb          = mem_wb_q;
  assign wb_valid        = wb_valid_q;
  assign mem_err         = mem_err_q;
  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;
  assign dmem.dmem_be    = be_q;

endmodule

// File: tb/tb_stage4_mem.sv
// Bench for stage4_mem: transaction-level expectation model plus
// per-cycle output comparison and literal spot checks.
module tb_stage4_mem;

  localparam int unsigned TO = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [3:0][31:0] ex_mem;
  logic             ex_valid;
  logic             mem_stall;
  logic [2:0][31:0] mem_wb;
  logic             wb_valid;
  logic             mem_err;

  stage4_mem_if bus ();

  stage4_mem #(.RESP_TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ex_mem    (ex_mem),
    .ex_valid  (ex_valid),
    .mem_stall (mem_stall),
    .dmem      (bus),
    .mem_wb    (mem_wb),
    .wb_valid  (wb_valid),
    .mem_err   (mem_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Expected values for the current cycle (e_*) and for after the next edge (p_*).
  logic        e_wbv = 1'b0, e_err = 1'b0, e_req = 1'b0, e_stall = 1'b0;
  logic [95:0] e_wb = '0;
  logic        p_wbv = 1'b0, p_err = 1'b0, p_req = 1'b0;
  logic [95:0] p_wb = '0;
  logic        x_we = 1'b0;
  logic [31:0] x_addr = '0, x_wdata = '0;
  logic [3:0]  x_be = '0;

  int          stall_cnt = 0;
  int          err_cnt = 0;
  logic [31:0] cap_addr = '0, cap_wdata = '0;
  logic [3:0]  cap_be = '0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---- specification model ----
  function automatic int m_size(input bit ld, input logic [2:0] f3);
    case (f3)
      3'd0: return 1;
      3'd1: return 2;
      3'd4: return ld ? 1 : 4;
      3'd5: return ld ? 2 : 4;
      default: return 4;
    endcase
  endfunction

  function automatic int m_lane(input int sz, input logic [1:0] a);
    if (sz == 1) return int'(a);
    if (sz == 2) return a[1] ? 2 : 0;
    return 0;
  endfunction

  function automatic logic [3:0] m_be(input int sz, input int lane);
    return 4'(((1 << sz) - 1) << lane);
  endfunction

  function automatic logic [31:0] m_wdata(input int sz, input logic [31:0] b);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = b[8*(i % sz) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_lmd(input logic [31:0] rd, input int sz, input int lane,
                                        input bit sgn);
    int v;
    if (sz == 4) return rd;
    v = 0;
    for (int i = 0; i < sz; i++) v += int'(rd[8*(lane+i) +: 8]) << (8*i);
    if (sgn && v >= (1 << (8*sz - 1))) v -= (1 << (8*sz));
    return 32'(v);
  endfunction

  function automatic logic [31:0] mk_ir(input logic [2:0] f3, input logic [6:0] op);
    return {17'h0, f3, 5'd1, op};
  endfunction

  // ---- per-cycle comparison ----
  always @(negedge clk) begin
    chk("wb_valid", 96'(wb_valid), 96'(e_wbv));
    chk("mem_wb", mem_wb, e_wb);
    chk("mem_err", 96'(mem_err), 96'(e_err));
    chk("dmem_req", 96'(bus.dmem_req), 96'(e_req));
    chk("mem_stall", 96'(mem_stall), 96'(e_stall));
    if (e_req) begin
      chk("dmem_addr", 96'(bus.dmem_addr), 96'(x_addr));
      chk("dmem_we", 96'(bus.dmem_we), 96'(x_we));
      chk("dmem_be", 96'(bus.dmem_be), 96'(x_be));
      if (x_we) chk("dmem_wdata", 96'(bus.dmem_wdata), 96'(x_wdata));
    end
    if (mem_stall) stall_cnt++;
    if (mem_err) err_cnt++;
    if (bus.dmem_req) begin
      cap_addr  = bus.dmem_addr;
      cap_wdata = bus.dmem_wdata;
      cap_be    = bus.dmem_be;
    end
  end

  // ---- stimulus helpers ----
  task automatic next_cycle();
    @(posedge clk);
    #1;
    e_wbv = p_wbv;
    if (p_wbv) e_wb = p_wb;
    e_err = p_err;
    e_req = p_req;
    p_wbv = 1'b0;
    p_err = 1'b0;
    bus.dmem_gnt    = 1'b0;
    bus.dmem_rvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      next_cycle();
      ex_valid = 1'b0;
      e_stall  = 1'b0;
    end
  endtask

  // One instruction through the stage; rv_wait < 0 means rvalid never comes.
  task automatic run_op(input logic [31:0] ir, input logic [31:0] alu, input logic [31:0] b,
                        input int gnt_wait, input int rv_wait, input logic [31:0] rdata);
    bit ld, st;
    int sz, lane;
    ld = (ir[6:0] == 7'b0000011);
    st = (ir[6:0] == 7'b0100011);
    next_cycle();
    ex_mem   = {b, alu, 32'h1, ir};
    ex_valid = 1'b1;
    if (!(ld || st)) begin
      e_stall = 1'b0;
      p_wbv   = 1'b1;
      p_wb    = {alu, 32'h0, ir};
      return;
    end
    sz   = m_size(ld, ir[14:12]);
    lane = m_lane(sz, alu[1:0]);
`ifdef MISALIGN_TRAP_EN
    if ((sz == 2 && alu[0]) || (sz == 4 && alu[1:0] != 2'b00)) begin
      e_stall = 1'b0;
      p_wbv   = 1'b1;
      p_err   = 1'b1;
      p_wb    = {alu, 32'h0, ir};
      return;
    end
`endif
    e_stall = 1'b1;
    p_req   = 1'b1;
    x_addr  = {alu[31:2], 2'b00};
    x_we    = st;
    x_be    = m_be(sz, lane);
    x_wdata = m_wdata(sz, b);
    for (int k = 0; k <= gnt_wait; k++) begin
      next_cycle();
      e_stall = 1'b1;
      if (k == gnt_wait) begin
        bus.dmem_gnt = 1'b1;
        p_req = 1'b0;
        if (st) begin
          e_stall = 1'b0;
          p_wbv   = 1'b1;
          p_wb    = {alu, 32'h0, ir};
        end
      end
    end
    if (st) return;
    for (int k = 0; k < int'(TO); k++) begin
      next_cycle();
      if (k == rv_wait) begin
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata  = rdata;
        e_stall = 1'b0;
        p_wbv   = 1'b1;
        p_wb    = {alu, m_lmd(rdata, sz, lane, ir[14] == 1'b0), ir};
        break;
      end else if (k == int'(TO) - 1) begin
        e_stall = 1'b0;
        p_wbv   = 1'b1;
        p_err   = 1'b1;
        p_wb    = {alu, 32'h0, ir};
        break;
      end else begin
        e_stall = 1'b1;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    ex_valid = 1'b0;
    ex_mem = '0;
    bus.dmem_gnt = 1'b0;
    bus.dmem_rvalid = 1'b0;
    bus.dmem_rdata = '0;
    next_cycle();
    next_cycle();
    reset_n = 1'b1;
    idle(1);

    // ALU op passes through in one cycle with no stall.
    stall_cnt = 0;
    run_op(32'h003100B3, 32'h10, 32'h0, 0, 0, 0);
    idle(1);
    chk("add_wbv", 96'(wb_valid), 96'(1));
    chk("add_alu", 96'(mem_wb[2]), 96'(32'h10));
    chk("add_lmd", 96'(mem_wb[1]), 96'(0));
    chk("add_stall_cycles", 96'(stall_cnt), 96'(0));

    // SW, grant after two REQ cycles.
    stall_cnt = 0;
    run_op(mk_ir(3'b010, 7'b0100011), 32'h100, 32'hDEADBEEF, 2, 0, 0);
    idle(1);
    chk("sw_stall_cycles", 96'(stall_cnt), 96'(3));
    chk("sw_be", 96'(cap_be), 96'(4'hF));
    chk("sw_wdata", 96'(cap_wdata), 96'(32'hDEADBEEF));
    chk("sw_addr", 96'(cap_addr), 96'(32'h100));
    chk("sw_wbv", 96'(wb_valid), 96'(1));

    // Loads with lane extraction.
    run_op(mk_ir(3'b000, 7'b0000011), 32'h103, 32'h0, 0, 1, 32'h80FF_0000);
    idle(1);
    chk("lb_lmd", 96'(mem_wb[1]), 96'(32'hFFFFFF80));
    run_op(mk_ir(3'b100, 7'b0000011), 32'h103, 32'h0, 1, 0, 32'h80FF_0000);
    idle(1);
    chk("lbu_lmd", 96'(mem_wb[1]), 96'(32'h00000080));
    run_op(mk_ir(3'b001, 7'b0000011), 32'h102, 32'h0, 0, 2, 32'h80FF_0000);
    idle(1);
    chk("lh_lmd", 96'(mem_wb[1]), 96'(32'hFFFF80FF));
    run_op(mk_ir(3'b101, 7'b0000011), 32'h102, 32'h0, 0, 0, 32'h80FF_0000);
    run_op(mk_ir(3'b010, 7'b0000011), 32'h104, 32'h0, 0, 0, 32'hCAFEF00D);
    run_op(mk_ir(3'b011, 7'b0000011), 32'h108, 32'h0, 0, 0, 32'h1234ABCD);
    idle(1);
    chk("ld_f3_other_lmd", 96'(mem_wb[1]), 96'(32'h1234ABCD));

    // Stores: byte, half, other funct3 treated as word; back-to-back with a load.
    run_op(mk_ir(3'b000, 7'b0100011), 32'h201, 32'h000000AB, 0, 0, 0);
    idle(1);
    chk("sb_be", 96'(cap_be), 96'(4'b0010));
    chk("sb_wdata", 96'(cap_wdata), 96'(32'hABABABAB));
    run_op(mk_ir(3'b001, 7'b0100011), 32'h202, 32'h00001234, 1, 0, 0);
    run_op(mk_ir(3'b100, 7'b0100011), 32'h208, 32'h55667788, 0, 0, 0);
    run_op(mk_ir(3'b010, 7'b0000011), 32'h20C, 32'h0, 0, 0, 32'h0BADF00D);
    run_op(32'h003100B3, 32'h44, 32'h0, 0, 0, 0);
    idle(2);

    // Load with no response: times out after TO WAIT cycles.
    err_cnt = 0;
    run_op(mk_ir(3'b010, 7'b0000011), 32'h300, 32'h0, 0, -1, 0);
    idle(1);
    chk("to_err", 96'(mem_err), 96'(1));
    chk("to_lmd", 96'(mem_wb[1]), 96'(0));
    chk("to_wbv", 96'(wb_valid), 96'(1));
    idle(1);
    chk("to_err_pulses", 96'(err_cnt), 96'(1));
    chk("to_stall", 96'(mem_stall), 96'(0));

    // Misaligned accesses.
`ifdef MISALIGN_TRAP_EN
    run_op(mk_ir(3'b010, 7'b0000011), 32'h102, 32'h0, 0, 0, 32'h11111111);
    idle(1);
    chk("trap_err", 96'(mem_err), 96'(1));
    chk("trap_wbv", 96'(wb_valid), 96'(1));
    chk("trap_req", 96'(bus.dmem_req), 96'(0));
    run_op(mk_ir(3'b001, 7'b0100011), 32'h103, 32'h5555, 0, 0, 0);
`else
    run_op(mk_ir(3'b001, 7'b0000011), 32'h101, 32'h0, 0, 0, 32'h12345678);
    idle(1);
    chk("mis_lh_lmd", 96'(mem_wb[1]), 96'(32'h00005678));
    run_op(mk_ir(3'b010, 7'b0100011), 32'h103, 32'hA5A5A5A5, 0, 0, 0);
    idle(1);
    chk("mis_sw_be", 96'(cap_be), 96'(4'hF));
`endif
    idle(1);

    // Reset in WAIT; a stale rvalid afterwards is ignored.
    next_cycle();
    ex_mem = {32'h0, 32'h400, 32'h1, mk_ir(3'b010, 7'b0000011)};
    ex_valid = 1'b1;
    e_stall = 1'b1;
    p_req = 1'b1;
    x_addr = 32'h400;
    x_we = 1'b0;
    x_be = 4'hF;
    next_cycle();
    bus.dmem_gnt = 1'b1;
    p_req = 1'b0;
    next_cycle();
    e_stall = 1'b1;
    next_cycle();
    reset_n = 1'b0;
    ex_valid = 1'b0;
    e_wbv = 1'b0; e_err = 1'b0; e_req = 1'b0; e_stall = 1'b0; e_wb = '0;
    p_wbv = 1'b0; p_err = 1'b0; p_req = 1'b0;
    next_cycle();
    next_cycle();
    reset_n = 1'b1;
    next_cycle();
    bus.dmem_rvalid = 1'b1;
    bus.dmem_rdata = 32'hDEADBEEF;
    idle(1);
    chk("rst_wbv", 96'(wb_valid), 96'(0));
    chk("rst_req", 96'(bus.dmem_req), 96'(0));
    chk("rst_lmd", 96'(mem_wb[1]), 96'(0));
    run_op(mk_ir(3'b000, 7'b0000011), 32'h500, 32'h0, 0, 0, 32'h0000007F);
    idle(1);
    chk("post_rst_lb", 96'(mem_wb[1]), 96'(32'h0000007F));
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
